// File: rtl/fix_mult_pkg.sv
// fix_mult_pkg: shared defaults, FSM encoding and counter-width helper for the fix_mult datapath
package fix_mult_pkg;
  localparam int Q_DEF = 8;
  localparam int N_DEF = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n - 1) : 1;
  endfunction
endpackage

// File: rtl/qmag_shift_add.sv
// qmag_shift_add: unsigned WxW shift-add core, P is the running product through the current bit
module qmag_shift_add #(
  parameter int W = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_m,
  input  logic [W-1:0]   b_m,
  output logic [2*W-1:0] P
);
  logic [2*W-1:0] acc, a_sh;
  logic [W-1:0]   b_sh;
  assign P = acc + (b_sh[0] ? a_sh : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (load) begin
      acc  <= '0;
      a_sh <= {{W{1'b0}}, a_m};
      b_sh <= b_m;
    end else if (step) begin
      acc  <= P;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
endmodule

// File: rtl/qmult_seq.sv
// qmult_seq: sequential sign-magnitude Q-format multiplier with saturated and full two's-complement results
module qmult_seq
  import fix_mult_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [N-1:0]   o_result,
  output logic           o_ovf,
  output logic [2*N-1:0] o_product
);
  localparam int CW = cnt_w(N);
  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           s, load, step, last, ovf;
  logic [2*N-3:0] p;
  logic [N-2:0]   r_m;
  logic [2*N-1:0] prod;
  assign load   = (state == IDLE) && i_start;
  assign step   = (state == CALC);
  assign last   = step && (cnt == CW'(N - 2));
  assign o_busy = (state == CALC);
  assign o_done = (state == DONE);
  qmag_shift_add #(.W(N - 1)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .a_m   (i_a[N-2:0]),
    .b_m   (i_b[N-2:0]),
    .P     (p)
  );
  always_comb begin
    state_nx = load ? CALC : last ? DONE : (state == DONE) ? IDLE : state;
    ovf      = |p[2*N-3:Q+N-1];
    r_m      = ovf ? '1 : p[Q+N-2:Q];
    prod     = s ? ~{2'b00, p} + (2*N)'(1) : {2'b00, p};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      s         <= 1'b0;
      o_result  <= '0;
      o_ovf     <= 1'b0;
      o_product <= '0;
    end else begin
      state <= state_nx;
      cnt   <= load ? '0 : step ? cnt + CW'(1) : cnt;
      s     <= load ? i_a[N-1] ^ i_b[N-1] : s;
      if (last) begin
        o_result  <= {s & |r_m, r_m};
        o_ovf     <= ovf;
        o_product <= prod;
      end
    end
endmodule

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: scoreboard bench for qmult_seq covering directed, overflow, busy-start, reset-abort and random cases
module tb_qmult_seq;
  localparam int Q = 8;
  localparam int N = 16;
  logic           clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
  logic [N-1:0]   i_a = '0, i_b = '0;
  logic           o_busy, o_done, o_ovf;
  logic [N-1:0]   o_result;
  logic [2*N-1:0] o_product;
  typedef struct packed {
    logic [N-1:0]   r;
    logic           ovf;
    logic [2*N-1:0] p;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, dones = 0;
  logic [N-1:0]   dir_a [4] = '{16'h0180, 16'h8180, 16'h6400, 16'h8001};
  logic [N-1:0]   dir_b [4] = '{16'h0200, 16'h0200, 16'h0400, 16'h0001};
  logic [N-1:0]   dir_r [4] = '{16'h0300, 16'h8300, 16'h7fff, 16'h0000};
  logic           dir_o [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [2*N-1:0] dir_p [4] = '{32'h0003_0000, 32'hfffd_0000, 32'h0190_0000, 32'hffff_ffff};
  qmult_seq #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_ovf     (o_ovf),
    .o_product (o_product)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (o_done) dones++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t        e;
    logic [31:0] p;
    logic        s, ov;
    logic [14:0] rm;
    p      = 32'(a[14:0]) * 32'(b[14:0]);
    s      = a[15] ^ b[15];
    ov     = p >= 32'h0080_0000;
    rm     = ov ? 15'h7fff : 15'(p >> Q);
    e.r    = {s && (rm != 15'd0), rm};
    e.ovf  = ov;
    e.p    = s ? 32'(-p) : p;
    return e;
  endfunction
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int inj);
    int   n, busy;
    exp_t e;
    busy = 0;
    @(negedge clk);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    sb.push_back(model(a, b));
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      i_start = (n == inj);
      if (n == inj) begin
        i_a = 16'h0100;
        i_b = 16'h0100;
      end
      if (o_busy) busy++;
      if (o_done) break;
    end
    chk("latency", 64'(n), 64'd16);
    chk("busy_cycles", 64'(busy), 64'd15);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (o_done) begin
      chk("result", 64'(o_result), 64'(e.r));
      chk("ovf", 64'(o_ovf), 64'(e.ovf));
      chk("product", 64'(o_product), 64'(e.p));
    end
    @(negedge clk);
    chk("done_pulse", 64'(o_done), 64'd0);
    chk("hold_result", 64'(o_result), 64'(e.r));
  endtask
  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_product", 64'(o_product), 64'd0);
    chk("rst_flags", 64'({o_busy, o_done, o_ovf}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(dir_a[i], dir_b[i], 0);
      chk("dir_result", 64'(o_result), 64'(dir_r[i]));
      chk("dir_ovf", 64'(o_ovf), 64'(dir_o[i]));
      chk("dir_product", 64'(o_product), 64'(dir_p[i]));
    end
    d0 = dones;
    run_op(16'h0300, 16'h8100, 5);
    repeat (20) @(negedge clk);
    chk("busy_start_dones", 64'(dones - d0), 64'd1);
    chk("idle_after", 64'(o_busy), 64'd0);
    @(negedge clk);
    i_a = 16'h0180;
    i_b = 16'h0200;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 64'(o_result), 64'd0);
    chk("abort_product", 64'(o_product), 64'd0);
    chk("abort_flags", 64'({o_busy, o_done, o_ovf}), 64'd0);
    d0 = dones;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(dones - d0), 64'd0);
    run_op(16'h0200, 16'h8080, 0);
    chk("post_rst_result", 64'(o_result), 64'h8100);
    for (int i = 0; i < 10; i++) run_op(16'($urandom), 16'($urandom), 0);
    run_op(16'hffff, 16'hffff, 0);
    run_op(16'h8000, 16'h7fff, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
